data_mem_responder: RTL and testbench

Data-side memory responder for the single-cycle MIPS core. It sits on the core's data memory port and answers every load and store. It holds a word-addressed RAM plus a small memory-mapped I/O window. The window provides a free-running cycle counter, a down-counting timer with a sticky expiry flag, and a transmit FIFO drained through a valid/ready output stream.

---
 rtl/data_mem_responder_if.sv | 22 ++
 rtl/data_mem_responder.sv | 112 +++++++++++
 tb/tb_data_mem_responder.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Data-memory port of the single-cycle core plus the TX stream and timer flag.
// Stream rule: a word moves on any rising edge where out_valid && out_ready are both high.
interface data_mem_responder_if;
  logic        data_mem_we;
  logic [31:0] data_mem_addr;
  logic [31:0] data_mem_wdata;
  logic [31:0] data_mem_rdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        timer_expired;

  modport slave (
    input  data_mem_we, data_mem_addr, data_mem_wdata, out_ready,
    output data_mem_rdata, out_valid, out_data, timer_expired
  );

  modport master (
    output data_mem_we, data_mem_addr, data_mem_wdata, out_ready,
    input  data_mem_rdata, out_valid, out_data, timer_expired
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-side responder: word RAM plus an MMIO window holding a cycle counter,
// a down-counting timer with sticky expiry, and a TX FIFO drained as a stream.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst,
  data_mem_responder_if.slave  bus
);
  localparam int            PW        = $clog2(FIFO_DEPTH);
  localparam int            RAM_WORDS = 1 << ADDR_WIDTH;
  localparam logic [PW:0]   DEPTH_C   = (PW+1)'(FIFO_DEPTH);

  logic [31:0]   r_ram [RAM_WORDS];
  logic [31:0]   r_fifo [FIFO_DEPTH];
  logic [31:0]   r_cycle;
  logic [31:0]   r_timer;
  logic          r_expired;
  logic          r_overflow;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;

  logic                  w_mmio;
  logic [7:0]            w_off;
  logic [ADDR_WIDTH-1:0] w_ram_idx;
  logic                  w_wr_timer, w_wr_status, w_wr_tx;
  logic                  w_full, w_empty, w_pop, w_push, w_ovf_set, w_expire_set;
  logic [31:0]           w_status;

  assign w_mmio      = (bus.data_mem_addr[31:8] == 24'hFFFFFF);
  assign w_off       = bus.data_mem_addr[7:0];
  assign w_ram_idx   = bus.data_mem_addr[ADDR_WIDTH+1:2];
  assign w_wr_timer  = bus.data_mem_we && w_mmio && (w_off == 8'h04);
  assign w_wr_status = bus.data_mem_we && w_mmio && (w_off == 8'h08);
  assign w_wr_tx     = bus.data_mem_we && w_mmio && (w_off == 8'h0C);

  assign w_full    = (r_count == DEPTH_C);
  assign w_empty   = (r_count == '0);
  assign w_pop     = !w_empty && bus.out_ready;
  // A pop frees the head slot in the same edge, so a push into a full FIFO still fits.
  assign w_push    = w_wr_tx && (!w_full || w_pop);
  assign w_ovf_set = w_wr_tx && w_full && !w_pop;
  // A timer write on the terminal cycle takes priority and suppresses expiry.
  assign w_expire_set = !w_wr_timer && (r_timer == 32'd1);

  assign bus.out_valid     = !w_empty;
  assign bus.out_data      = w_empty ? 32'd0 : r_fifo[r_rd_ptr];
  assign bus.timer_expired = r_expired;

  always_comb begin
    w_status           = '0;
    w_status[0]        = w_full;
    w_status[1]        = w_empty;
    w_status[2]        = r_expired;
    w_status[3]        = r_overflow;
    w_status[8+PW:8]   = r_count;
  end

  always_comb begin
    bus.data_mem_rdata = '0;
    if (!w_mmio) begin
      bus.data_mem_rdata = r_ram[w_ram_idx];
    end else begin
      case (w_off)
        8'h00:   bus.data_mem_rdata = r_cycle;
        8'h04:   bus.data_mem_rdata = r_timer;
        8'h08:   bus.data_mem_rdata = w_status;
        default: bus.data_mem_rdata = '0;
      endcase
    end
  end

  // RAM and FIFO storage are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (bus.data_mem_we && !w_mmio) r_ram[w_ram_idx] <= bus.data_mem_wdata;
    if (w_push) r_fifo[r_wr_ptr] <= bus.data_mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle    <= '0;
      r_timer    <= '0;
      r_expired  <= 1'b0;
      r_overflow <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;

      if (w_wr_timer)          r_timer <= bus.data_mem_wdata;
      else if (r_timer != '0)  r_timer <= r_timer - 32'd1;

      if (w_expire_set)                              r_expired <= 1'b1;
      else if (w_wr_status && bus.data_mem_wdata[2]) r_expired <= 1'b0;

      if (w_ovf_set)                                 r_overflow <= 1'b1;
      else if (w_wr_status && bus.data_mem_wdata[3]) r_overflow <= 1'b0;

      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, hand-written corner
// sequences and random traffic, all checked against a queue/array-based model.
module tb_data_mem_responder;
  localparam int AW    = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_responder_if bus();

  data_mem_responder #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: RAM as a sparse array, time as a cycle count, timer as a deadline.
  logic [31:0] m_ram [int];
  longint      m_t;
  longint      m_deadline;
  bit          m_armed, m_exp, m_ovf;
  logic [31:0] exp_q [$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rdy;
    bit          chk;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s       = '0;
    s[0]    = (exp_q.size() == DEPTH);
    s[1]    = (exp_q.size() == 0);
    s[2]    = m_exp;
    s[3]    = m_ovf;
    s[10:8] = 3'(exp_q.size());
    return s;
  endfunction

  function automatic bit m_read(input logic [31:0] a, output logic [31:0] v);
    int idx;
    v = '0;
    if (a[31:8] == 24'hFFFFFF) begin
      case (a[7:0])
        8'h00:   v = 32'(m_t);
        8'h04:   v = m_armed ? 32'(m_deadline - m_t) : 32'd0;
        8'h08:   v = m_status();
        default: v = '0;
      endcase
      return 1'b1;
    end
    idx = int'(a[AW+1:2]);
    if (m_ram.exists(idx)) begin
      v = m_ram[idx];
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic idle_inputs();
    bus.data_mem_we    = 1'b0;
    bus.data_mem_addr  = 32'h0;
    bus.data_mem_wdata = 32'h0;
    bus.out_ready      = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    m_t        = 0;
    m_armed    = 1'b0;
    m_exp      = 1'b0;
    m_ovf      = 1'b0;
    exp_q.delete();
  endtask

  // One core cycle: drive, check combinational outputs mid-cycle, then advance the model at the edge.
  task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic rdy, input bit chk = 1'b0, input logic [31:0] exp_rd = 32'h0);
    logic [31:0] mv;
    bit known, mmio, twr, pop, fire;
    bus.data_mem_we    = we;
    bus.data_mem_addr  = a;
    bus.data_mem_wdata = wd;
    bus.out_ready      = rdy;
    @(negedge clk);
    known = m_read(a, mv);
    if (known) check("rdata", bus.data_mem_rdata, mv);
    if (chk)   check("rdata_vec", bus.data_mem_rdata, exp_rd);
    check("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_q.size() != 0});
    check("out_data", bus.out_data, (exp_q.size() != 0) ? exp_q[0] : 32'd0);
    check("timer_expired", {31'd0, bus.timer_expired}, {31'd0, m_exp});
    @(posedge clk);
    mmio = (a[31:8] == 24'hFFFFFF);
    twr  = we && mmio && (a[7:0] == 8'h04);
    pop  = rdy && (exp_q.size() != 0);
    fire = m_armed && !twr && (m_deadline == m_t + 1);
    if (pop) void'(exp_q.pop_front());
    if (we && !mmio) m_ram[int'(a[AW+1:2])] = wd;
    if (we && mmio) begin
      case (a[7:0])
        8'h04: begin
          if (wd == 32'd0) m_armed = 1'b0;
          else begin
            m_armed    = 1'b1;
            m_deadline = m_t + 1 + longint'(wd);
          end
        end
        8'h08: begin
          if (wd[2]) m_exp = 1'b0;
          if (wd[3]) m_ovf = 1'b0;
        end
        8'h0C: begin
          if (exp_q.size() < DEPTH) exp_q.push_back(wd);
          else m_ovf = 1'b1;
        end
        default: ;
      endcase
    end
    if (fire) begin
      m_exp   = 1'b1;
      m_armed = 1'b0;
    end
    m_t++;
    #1;
  endtask

  initial begin
    logic [31:0] a, wd;
    logic        we, rdy;

    vecs[0]  = '{1'b0, 32'hFFFFFF00, 32'h0,        1'b0, 1'b1, 32'd0};
    vecs[1]  = '{1'b1, 32'h00000010, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0};
    vecs[2]  = '{1'b0, 32'h00000010, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    vecs[3]  = '{1'b0, 32'h00000410, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    vecs[4]  = '{1'b0, 32'h00000013, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    vecs[5]  = '{1'b0, 32'hFFFFFF00, 32'h0,        1'b0, 1'b1, 32'd5};
    vecs[6]  = '{1'b1, 32'hFFFFFF00, 32'h1234,     1'b0, 1'b1, 32'd6};
    vecs[7]  = '{1'b0, 32'hFFFFFF00, 32'h0,        1'b0, 1'b1, 32'd7};
    vecs[8]  = '{1'b0, 32'hFFFFFF0C, 32'h0,        1'b0, 1'b1, 32'd0};
    vecs[9]  = '{1'b0, 32'hFFFFFF08, 32'h0,        1'b0, 1'b1, 32'h2};
    vecs[10] = '{1'b0, 32'hFFFFFF40, 32'h0,        1'b0, 1'b1, 32'd0};

    do_reset();
    for (int i = 0; i < 11; i++)
      cyc(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdy, vecs[i].chk, vecs[i].exp_rd);

    // Timer countdown, expiry, W1C, and reload on the terminal cycle.
    cyc(1'b1, 32'hFFFFFF04, 32'd3, 1'b0);
    cyc(1'b0, 32'hFFFFFF04, 32'd0, 1'b0, 1'b1, 32'd3);
    cyc(1'b0, 32'hFFFFFF04, 32'd0, 1'b0, 1'b1, 32'd2);
    cyc(1'b0, 32'hFFFFFF04, 32'd0, 1'b0, 1'b1, 32'd1);
    cyc(1'b0, 32'hFFFFFF04, 32'd0, 1'b0, 1'b1, 32'd0);
    check("timer_expired_set", {31'd0, bus.timer_expired}, 32'd1);
    cyc(1'b0, 32'hFFFFFF08, 32'd0, 1'b0, 1'b1, 32'h6);
    cyc(1'b1, 32'hFFFFFF08, 32'h4, 1'b0);
    cyc(1'b0, 32'hFFFFFF08, 32'd0, 1'b0, 1'b1, 32'h2);
    cyc(1'b1, 32'hFFFFFF04, 32'd2, 1'b0);
    cyc(1'b0, 32'hFFFFFF04, 32'd0, 1'b0, 1'b1, 32'd2);
    cyc(1'b1, 32'hFFFFFF04, 32'd5, 1'b0, 1'b1, 32'd1);
    cyc(1'b0, 32'hFFFFFF04, 32'd0, 1'b0, 1'b1, 32'd5);
    check("reload_no_expire", {31'd0, bus.timer_expired}, 32'd0);
    cyc(1'b1, 32'hFFFFFF04, 32'd0, 1'b0);
    cyc(1'b0, 32'hFFFFFF04, 32'd0, 1'b0, 1'b1, 32'd0);

    // FIFO overflow then drain.
    for (int i = 1; i <= 5; i++) cyc(1'b1, 32'hFFFFFF0C, 32'(i), 1'b0);
    cyc(1'b0, 32'hFFFFFF08, 32'd0, 1'b0, 1'b1, 32'h409);
    for (int i = 1; i <= 4; i++) begin
      check("drain_order", bus.out_data, 32'(i));
      cyc(1'b0, 32'hFFFFFF08, 32'd0, 1'b1);
    end
    cyc(1'b1, 32'hFFFFFF08, 32'h8, 1'b1, 1'b1, 32'hA);
    cyc(1'b0, 32'hFFFFFF08, 32'd0, 1'b0, 1'b1, 32'h2);

    // Push while full with a simultaneous pop.
    for (int i = 5; i <= 8; i++) cyc(1'b1, 32'hFFFFFF0C, 32'(i), 1'b0);
    cyc(1'b1, 32'hFFFFFF0C, 32'd9, 1'b1, 1'b1, 32'd0);
    cyc(1'b0, 32'hFFFFFF08, 32'd0, 1'b0, 1'b1, 32'h401);
    for (int i = 6; i <= 9; i++) begin
      check("full_pushpop_order", bus.out_data, 32'(i));
      cyc(1'b0, 32'hFFFFFF00, 32'd0, 1'b1);
    end

    // Reset in the middle of activity.
    cyc(1'b1, 32'h00000020, 32'hCAFEF00D, 1'b0);
    cyc(1'b1, 32'hFFFFFF0C, 32'h11, 1'b0);
    cyc(1'b1, 32'hFFFFFF0C, 32'h22, 1'b0);
    cyc(1'b1, 32'hFFFFFF04, 32'd100, 1'b0);
    cyc(1'b0, 32'hFFFFFF04, 32'd0, 1'b0, 1'b1, 32'd100);
    do_reset();
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    cyc(1'b0, 32'hFFFFFF00, 32'd0, 1'b0, 1'b1, 32'd0);
    cyc(1'b0, 32'hFFFFFF04, 32'd0, 1'b0, 1'b1, 32'd0);
    cyc(1'b0, 32'h00000020, 32'd0, 1'b0, 1'b1, 32'hCAFEF00D);

    // Random traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      we  = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 2) != 0);
      wd  = $urandom();
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: a = 32'(($urandom_range(0, 3) << 10) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
        5:       a = 32'hFFFFFF00;
        6: begin a = 32'hFFFFFF04; wd = 32'($urandom_range(0, 6)); end
        7:       a = 32'hFFFFFF08;
        8:       a = 32'hFFFFFF0C;
        default: a = 32'hFFFFFF00 | 32'($urandom_range(4, 63) << 2);
      endcase
      cyc(we, a, wd, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
